// File: rtl/adc_trigger_pkg.sv
// Shared types for the multi-channel hysteresis trigger core:
// FSM state encoding and edge-mode codes.
package adc_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    WAIT_LOW  = 2'd2,
    HOLDOFF   = 2'd3
  } trig_state_e;

  localparam logic [1:0] EDGE_RISING  = 2'b00;
  localparam logic [1:0] EDGE_FALLING = 2'b01;
  localparam logic [1:0] EDGE_EITHER  = 2'b10;

  function automatic logic edge_rise_ok(input logic [1:0] m);
    return (m == EDGE_RISING) || m[1];
  endfunction

  function automatic logic edge_fall_ok(input logic [1:0] m);
    return (m == EDGE_FALLING) || m[1];
  endfunction

endpackage

// File: rtl/adc_trigger_core_multi_edge_if.sv
// Comparator, configuration and status bundle between the ADC
// front end / trigger controller (master) and the core (slave).
interface adc_trigger_core_multi_edge_if #(
  parameter int NUM_CH    = 4,
  parameter int HOLDOFF_W = 16
);
  logic                 comp_ena;
  logic                 comp_pol;
  logic [1:0]           edge_mode;
  logic [NUM_CH-1:0]    ch_mask;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [NUM_CH-1:0]    adc_hi_comp;
  logic [NUM_CH-1:0]    adc_lo_comp;
  logic                 comp_sig;
  logic [NUM_CH-1:0]    comp_ch;
  logic                 trig_pulse;
  logic [31:0]          trig_count;
  logic [1:0]           dbg_comp_state;

  modport master (
    output comp_ena, comp_pol, edge_mode, ch_mask, holdoff,
    output adc_hi_comp, adc_lo_comp,
    input  comp_sig, comp_ch, trig_pulse, trig_count,
    input  dbg_comp_state
  );

  modport slave (
    input  comp_ena, comp_pol, edge_mode, ch_mask, holdoff,
    input  adc_hi_comp, adc_lo_comp,
    output comp_sig, comp_ch, trig_pulse, trig_count,
    output dbg_comp_state
  );
endinterface

// File: rtl/adc_trigger_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot winner plus any-hit.
// Purely combinational.
module adc_trigger_prio_enc #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] hit,
  output logic [NUM_CH-1:0] onehot,
  output logic              any_hit
);
  // Two's-complement trick isolates the lowest set bit.
  assign onehot  = hit & (~hit + NUM_CH'(1));
  assign any_hit = |hit;
endmodule

// File: rtl/adc_trigger_core_multi_edge.sv
// Multi-channel hysteresis trigger core with edge qualification and holdoff.
// Optional event counter: define ADC_TRIGGER_EVENT_COUNTER_EN.
module adc_trigger_core_multi_edge
  import adc_trigger_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int HOLDOFF_W = 16
) (
  input  logic adc_data_clk,
  input  logic comp_rst,
  adc_trigger_core_multi_edge_if.slave bus
);

  trig_state_e          state_q, state_d;
  trig_state_e          after_q, after_d;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]    ch_q, ch_d;
  logic                 sig_q, sig_d;
  logic                 trig_q, trig_d;

  logic [NUM_CH-1:0]    hit;
  logic [NUM_CH-1:0]    hit_oh;
  logic                 hit_any;
  logic [HOLDOFF_W-1:0] hmax;

  // Only the flag relevant to the current wait state is looked at.
  assign hit = ((state_q == WAIT_LOW) ? bus.adc_lo_comp
                                      : bus.adc_hi_comp) & bus.ch_mask;

  adc_trigger_prio_enc #(.NUM_CH(NUM_CH)) u_prio (
    .hit     (hit),
    .onehot  (hit_oh),
    .any_hit (hit_any)
  );

  assign hmax = (bus.holdoff == '0) ? HOLDOFF_W'(1) : bus.holdoff;

  always_comb begin
    state_d = state_q;
    after_d = after_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    sig_d   = sig_q;
    trig_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.comp_ena) begin
          state_d = WAIT_HIGH;
          ch_d    = '0;
          sig_d   = 1'b0;
        end
      end
      WAIT_HIGH: begin
        if (bus.comp_ena && hit_any) begin
          ch_d    = hit_oh;
          sig_d   = 1'b1;
          after_d = WAIT_LOW;
          cnt_d   = HOLDOFF_W'(1);
          state_d = HOLDOFF;
          trig_d  = edge_rise_ok(bus.edge_mode);
        end
      end
      WAIT_LOW: begin
        if (bus.comp_ena && hit_any) begin
          ch_d    = hit_oh;
          sig_d   = 1'b0;
          after_d = WAIT_HIGH;
          cnt_d   = HOLDOFF_W'(1);
          state_d = HOLDOFF;
          trig_d  = edge_fall_ok(bus.edge_mode);
        end
      end
      HOLDOFF: begin
        // >= lets a live holdoff shrink below the count exit at once.
        if (cnt_q >= hmax) state_d = after_q;
        else               cnt_d   = cnt_q + HOLDOFF_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_data_clk or posedge comp_rst) begin
    if (comp_rst) begin
      state_q <= IDLE;
      after_q <= WAIT_HIGH;
      cnt_q   <= '0;
      ch_q    <= '0;
      sig_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      after_q <= after_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      sig_q   <= sig_d;
      trig_q  <= trig_d;
    end
  end

`ifdef ADC_TRIGGER_EVENT_COUNTER_EN
  logic [31:0] trig_count_q, trig_count_d;

  assign trig_count_d = trig_q ? trig_count_q + 32'd1 : trig_count_q;

  always_ff @(posedge adc_data_clk or posedge comp_rst) begin
    if (comp_rst) trig_count_q <= '0;
    else          trig_count_q <= trig_count_d;
  end

  assign bus.trig_count = trig_count_q;
`else
  assign bus.trig_count = '0;
`endif

  assign bus.comp_sig       = bus.comp_pol ? ~sig_q : sig_q;
  assign bus.comp_ch        = ch_q;
  assign bus.trig_pulse     = trig_q;
  assign bus.dbg_comp_state = state_q;

endmodule

// File: tb/tb_adc_trigger_core_multi_edge.sv
// Directed-vector bench for adc_trigger_core_multi_edge.
// Counter checks follow ADC_TRIGGER_EVENT_COUNTER_EN.
module tb_adc_trigger_core_multi_edge;

  localparam int NCH = 4;
  localparam int HW  = 16;

  logic adc_data_clk = 1'b0;
  logic comp_rst     = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   npulse;

  adc_trigger_core_multi_edge_if #(.NUM_CH(NCH), .HOLDOFF_W(HW)) bus ();

  adc_trigger_core_multi_edge #(.NUM_CH(NCH), .HOLDOFF_W(HW)) dut (
    .adc_data_clk (adc_data_clk),
    .comp_rst     (comp_rst),
    .bus          (bus)
  );

  always #5 adc_data_clk = ~adc_data_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs driven 1 unit later.
  task automatic tick();
    @(posedge adc_data_clk);
    #1;
  endtask

  task automatic out(input string tag, input logic [1:0] st,
                     input logic tp, input logic [3:0] ch,
                     input logic sg);
    chk({tag, "_state"}, 32'(bus.dbg_comp_state), 32'(st));
    chk({tag, "_trig"},  32'(bus.trig_pulse),     32'(tp));
    chk({tag, "_ch"},    32'(bus.comp_ch),        32'(ch));
    chk({tag, "_sig"},   32'(bus.comp_sig),       32'(sg));
  endtask

  initial begin
    bus.comp_ena    = 1'b0;
    bus.comp_pol    = 1'b0;
    bus.edge_mode   = 2'b00;
    bus.ch_mask     = 4'b1111;
    bus.holdoff     = 16'd5;
    bus.adc_hi_comp = '0;
    bus.adc_lo_comp = '0;
    #12;
    out("rst", 2'd0, 1'b0, 4'b0000, 1'b0);
    chk("rst_count", bus.trig_count, 32'd0);
    bus.comp_pol = 1'b1;
    #1;
    chk("rst_pol_sig", 32'(bus.comp_sig), 32'd1);
    bus.comp_pol = 1'b0;
    #1;
    tick();
    comp_rst = 1'b0;
    tick();
    chk("idle_no_ena", 32'(bus.dbg_comp_state), 32'd0);
    bus.comp_ena = 1'b1;
    tick();
    out("to_wh", 2'd1, 1'b0, 4'b0000, 1'b0);

    // Rising mode, single channel, holdoff 5.
    bus.adc_hi_comp = 4'b0100;
    tick();
    bus.adc_hi_comp = 4'b0000;
    out("rise", 2'd3, 1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      out("rise_ho", 2'd3, 1'b0, 4'b0100, 1'b1);
    end
    tick();
    out("rise_wl", 2'd2, 1'b0, 4'b0100, 1'b1);

    // Falling mode, holdoff 0 gives a single holdoff cycle.
    bus.edge_mode   = 2'b01;
    bus.holdoff     = 16'd0;
    bus.adc_lo_comp = 4'b0001;
    tick();
    bus.adc_lo_comp = 4'b0000;
    out("fall1", 2'd3, 1'b1, 4'b0001, 1'b0);
    tick();
    out("fall1_wh", 2'd1, 1'b0, 4'b0001, 1'b0);
    bus.adc_hi_comp = 4'b0001;
    tick();
    bus.adc_hi_comp = 4'b0000;
    out("fall_hi", 2'd3, 1'b0, 4'b0001, 1'b1);
    tick();
    out("ho0_wl", 2'd2, 1'b0, 4'b0001, 1'b1);
    bus.adc_lo_comp = 4'b0001;
    tick();
    bus.adc_lo_comp = 4'b0000;
    out("fall_lo", 2'd3, 1'b1, 4'b0001, 1'b0);
    tick();

    // Priority under masking, either-edge mode.
    bus.edge_mode   = 2'b10;
    bus.ch_mask     = 4'b1101;
    bus.adc_hi_comp = 4'b1010;
    tick();
    bus.adc_hi_comp = 4'b0000;
    out("prio", 2'd3, 1'b1, 4'b1000, 1'b1);
    tick();

    // Fully masked: nothing for 100 cycles.
    bus.ch_mask     = 4'b0000;
    bus.adc_lo_comp = 4'b1111;
    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.trig_pulse) npulse++;
    end
    chk("mask0_pulses", 32'(npulse), 32'd0);
    out("mask0", 2'd2, 1'b0, 4'b1000, 1'b1);
    bus.ch_mask     = 4'b1111;
    bus.adc_lo_comp = 4'b0010;
    tick();
    bus.adc_lo_comp = 4'b0000;
    out("lo_ch1", 2'd3, 1'b1, 4'b0010, 1'b0);
    tick();

    // Hi held through holdoff 3: exactly one pulse, then wait for lo.
    bus.holdoff     = 16'd3;
    bus.adc_hi_comp = 4'b0001;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.trig_pulse) npulse++;
    end
    chk("hold_pulses", 32'(npulse), 32'd1);
    out("hold_wl", 2'd2, 1'b0, 4'b0001, 1'b1);
    bus.adc_hi_comp = 4'b0000;
    bus.adc_lo_comp = 4'b0100;
    tick();
    bus.adc_lo_comp = 4'b0000;
    out("hold_lo", 2'd3, 1'b1, 4'b0100, 1'b0);

    // comp_ena low in WAIT_LOW freezes everything.
    bus.holdoff = 16'd0;
    tick();
    bus.adc_hi_comp = 4'b1000;
    tick();
    bus.adc_hi_comp = 4'b0000;
    out("ena_hi", 2'd3, 1'b1, 4'b1000, 1'b1);
    tick();
    bus.comp_ena    = 1'b0;
    bus.adc_lo_comp = 4'b1111;
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.trig_pulse) npulse++;
    end
    chk("ena_pulses", 32'(npulse), 32'd0);
    out("ena_hold", 2'd2, 1'b0, 4'b1000, 1'b1);
    bus.adc_lo_comp = 4'b0000;
    bus.comp_ena    = 1'b1;

    // Asynchronous reset mid-holdoff.
    bus.holdoff     = 16'd5;
    bus.adc_lo_comp = 4'b0001;
    tick();
    bus.adc_lo_comp = 4'b0000;
    out("pre_rst", 2'd3, 1'b1, 4'b0001, 1'b0);
    tick();
    comp_rst = 1'b1;
    #1;
    out("async_rst", 2'd0, 1'b0, 4'b0000, 1'b0);
    chk("async_rst_count", bus.trig_count, 32'd0);
    #5;
    comp_rst = 1'b0;
    tick();
    out("rst_wh", 2'd1, 1'b0, 4'b0000, 1'b0);

    // Ten alternating crossings in either-edge mode.
    bus.holdoff = 16'd0;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) bus.adc_hi_comp = 4'b0001;
      else            bus.adc_lo_comp = 4'b0001;
      tick();
      if (bus.trig_pulse) npulse++;
      bus.adc_hi_comp = 4'b0000;
      bus.adc_lo_comp = 4'b0000;
      tick();
    end
    chk("alt_pulses", 32'(npulse), 32'd10);
`ifdef ADC_TRIGGER_EVENT_COUNTER_EN
    chk("count10", bus.trig_count, 32'd10);
    force dut.trig_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.trig_count_q;
    bus.adc_hi_comp = 4'b0001;
    tick();
    bus.adc_hi_comp = 4'b0000;
    chk("wrap_pre", bus.trig_count, 32'hFFFF_FFFF);
    tick();
    chk("wrap", bus.trig_count, 32'd0);
`else
    chk("count_tied", bus.trig_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
